instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface.
- Owns the program counter and drives word-aligned fetch addresses into the asynchronous-read instruction ROM, which returns the word in the same cycle.
- Captures {pc, instr} pairs into a small fetch buffer and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute and flushes wrong-path entries.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (ALEN bits).
- BUF_DEPTH, 2, fetch-buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- fetch_en  input  1  core run enable; low = issue no new fetches.
- redirect_valid  input  1  PC redirect request from execute.
- redirect_pc  input  ALEN  redirect target.
- imem_en  output  1  fetch request to instruction memory.
- imem_addr  output  ALEN  byte address to instruction memory.
- imem_instr  input  32  instruction word, valid combinationally in the same cycle.
- if_valid  output  1  buffer head valid toward decode.
- if_ready  input  1  decode accepts head this cycle.
- if_pc  output  ALEN  PC of head entry.
- if_instr  output  32  instruction of head entry.
- if_exc  output  1  head entry is an instruction-address-misaligned marker; tied 0 without the feature.

Behaviour:
- Reset, asynchronous, while rst = 0:
  - pc = RESET_PC, buffer empty, state = RUN.
  - Outputs: if_valid = 0, if_pc = 0, if_instr = 0, if_exc = 0, imem_en = 0, imem_addr = pc.
- Release of rst is synchronous to clk. Reset mid-operation discards all buffered entries.
- States:
  - RUN: normal fetching.
  - HALT: entered only through the optional feature; no fetches.
- Pop: occurs when if_valid & if_ready.
- Space is available when count < BUF_DEPTH, or when the buffer is full and a pop occurs in the same cycle.
- Fetch, in RUN:
  - imem_en = fetch_en & space & ~redirect_valid; imem_addr = pc.
  - On a fetch, push {pc, imem_instr} at the tail and set pc <= pc + 4.
  - Latency: ROM address to buffered entry is one cycle; if_valid rises the cycle after the first fetch.
- Throughput: one instruction per cycle sustained while if_ready = 1.
- Redirect has priority over fetch and pop:
  - Flush the buffer (count <= 0), set pc <= {redirect_pc[ALEN-1:2], 2'b00}.
  - imem_en = 0 that cycle; the next cycle fetches the target.
  - A concurrent if_ready is ignored (no pop).
- Buffer full with if_ready = 0: imem_en = 0, pc holds, head is stable.
- Output stability: if_pc, if_instr and if_exc must not change while if_valid & ~if_ready.
- fetch_en low: no pushes; buffered entries still drain to decode.
- Arithmetic: pc + 4 wraps modulo 2^ALEN with no flag; imem_addr[1:0] is always 00.
- Empty buffer: if_valid = 0; if_pc and if_instr hold their last value.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 does the following:
  - Flushes the buffer.
  - Pushes one entry {redirect_pc, 32'h00000013, exc = 1} on the next cycle.
  - Enters HALT, which issues no fetches.
  - HALT is left only by the next redirect_valid, which is processed normally, or by reset.
- Undefined: low target bits are silently cleared; if_exc is constant 0; HALT is unreachable and removed.

Decomposition:
- riscv_pkg holds:
  - ALEN and the NOP constant 32'h00000013.
  - Typedef fetch_entry_t {pc, instr, exc}.
  - State enum fetch_state_e {RUN, HALT}.
- Sub-module fetch_buffer: a parameterised synchronous FIFO of fetch_entry_t, with flush, push, pop, count, full and empty, and same-cycle push+pop when full.

Test Plan:
1. Reset release, fetch_en = 1, if_ready = 1, ROM words 0x00500093 at 0x0 and 0x00A00113 at 0x4 → cycle 1 if_pc = 0x0, if_instr = 0x00500093; cycle 2 if_pc = 0x4, if_instr = 0x00A00113; one instruction per cycle.
2. if_ready = 0 for 5 cycles after the first fetch → count saturates at 2, imem_en = 0, pc holds 0x8, if_pc stays 0x0; raise if_ready → entries 0x0, 0x4, 0x8 come out in order with no gap.
3. redirect_valid = 1, redirect_pc = 0x100 while 2 entries are buffered and if_ready = 1 → no pop; if_valid = 0 next cycle; the following entry has if_pc = 0x100.
4. pc = 0xFFFF_FFFC, fetch → next fetch address 0x0000_0000, with no hang.
5. Drive rst low mid-stream with 2 entries buffered → if_valid drops immediately (asynchronously); after release the first if_pc = RESET_PC.
6. With FETCH_MISALIGN_TRAP_EN, redirect_pc = 0x102 → one entry with if_pc = 0x102, if_exc = 1, if_instr = 0x00000013, then imem_en = 0 until a redirect to 0x200, which resumes fetching at 0x200.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared address width, NOP encoding, fetch-buffer entry and fetch FSM state.
package riscv_pkg;
   localparam int          ALEN = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef struct packed {
      logic [ALEN-1:0] pc;
      logic [31:0]     instr;
      logic            exc;
   } fetch_entry_t;

   typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch entries with flush, and push+pop in the same cycle when full.
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  fetch_entry_t             din_i,
   output fetch_entry_t             dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem_q [DEPTH];
   logic [AW-1:0]  rd_q, wr_q;
   logic [AW:0]    cnt_q;
   logic           do_pop, do_push;

   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign do_push = push_i & (flush_i | ~full_o | do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         // A push alongside a flush lands in slot 0 of the freshly emptied buffer.
         rd_q  <= '0;
         wr_q  <= AW'(push_i);
         cnt_q <= (AW+1)'(push_i);
      end else begin
         rd_q  <= rd_q + AW'(do_pop);
         wr_q  <= wr_q + AW'(do_push);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[flush_i ? '0 : wr_q] <= din_i;
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and fetch-buffer front end toward decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect pushes a trap marker entry and halts fetching.
module instruction_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [ALEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_en,
   input  logic            redirect_valid,
   input  logic [ALEN-1:0] redirect_pc,
   output logic            imem_en,
   output logic [ALEN-1:0] imem_addr,
   input  logic [31:0]     imem_instr,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [ALEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   output logic            if_exc
);
   logic [ALEN-1:0]              pc_q, pc_d;
   fetch_entry_t                 head, hold_q, out, push_entry;
   logic [$clog2(BUF_DEPTH):0]   count;
   logic                         full, empty, pop, space, push, may_fetch;

   assign if_valid  = ~empty;
   assign pop       = if_valid & if_ready & ~redirect_valid;
   assign space     = (count < ($clog2(BUF_DEPTH)+1)'(BUF_DEPTH)) | (full & if_valid & if_ready);
   assign imem_en   = rst & may_fetch & fetch_en & space & ~redirect_valid;
   assign imem_addr = pc_q;
   assign pc_d      = redirect_valid ? (redirect_pc & ~ALEN'(3)) : imem_en ? pc_q + ALEN'(4) : pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
   fetch_state_e state_q, state_d;
   logic         trap;
   assign trap       = redirect_valid & |redirect_pc[1:0];
   assign may_fetch  = state_q == RUN;
   assign push       = imem_en | trap;
   assign push_entry = trap ? '{pc: redirect_pc, instr: NOP, exc: 1'b1} : '{pc: pc_q, instr: imem_instr, exc: 1'b0};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= RUN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) state_d = trap ? HALT : RUN;
   end
`else
   assign may_fetch  = 1'b1;
   assign push       = imem_en;
   assign push_entry = '{pc: pc_q, instr: imem_instr, exc: 1'b0};
`endif

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_valid),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (push_entry),
      .dout_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   // Decode sees the last presented entry while the buffer is empty.
   assign out      = if_valid ? head : hold_q;
   assign if_pc    = out.pc;
   assign if_instr = out.instr;
   assign if_exc   = out.exc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= RESET_PC;
         hold_q <= '0;
      end else begin
         pc_q   <= pc_d;
         if (if_valid) hold_q <= head;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed table, corner sequences and queue-model random checks.
module tb_instruction_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fe = 1'b0, rd = 1'b0, rdy = 1'b0;
   logic [31:0] rpc = '0;
   logic        imem_en, if_valid, if_exc;
   logic [31:0] imem_addr, imem_instr, if_pc, if_instr;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   assign imem_instr = rom(imem_addr);

   instruction_fetch_unit dut (
      .clk(clk), .rst(rst), .fetch_en(fe), .redirect_valid(rd), .redirect_pc(rpc),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .if_valid(if_valid), .if_ready(rdy), .if_pc(if_pc), .if_instr(if_instr), .if_exc(if_exc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic fe, rd, rdy;
      logic [31:0] rpc;
      logic v;
      logic [31:0] pc, instr;
      logic en;
      logic [31:0] addr;
   } vec_t;

   typedef struct {
      logic [31:0] pc, instr;
      logic exc;
   } ent_t;

   vec_t vt [12];
   ent_t m_q [$];
   ent_t m_last, hd;
   logic [31:0] m_pc;
   logic m_halt, m_v, m_pop, m_en;

   initial begin
      vt[0]  = '{1,0,1,0,        0,32'h0,  32'h0,        1,32'h0};
      vt[1]  = '{1,0,1,0,        1,32'h0,  rom(32'h0),   1,32'h4};
      vt[2]  = '{1,0,1,0,        1,32'h4,  rom(32'h4),   1,32'h8};
      vt[3]  = '{1,0,0,0,        1,32'h8,  rom(32'h8),   1,32'hC};
      vt[4]  = '{1,0,0,0,        1,32'h8,  rom(32'h8),   0,32'h10};
      vt[5]  = '{1,0,0,0,        1,32'h8,  rom(32'h8),   0,32'h10};
      vt[6]  = '{1,0,0,0,        1,32'h8,  rom(32'h8),   0,32'h10};
      vt[7]  = '{1,0,1,0,        1,32'h8,  rom(32'h8),   1,32'h10};
      vt[8]  = '{1,0,1,0,        1,32'hC,  rom(32'hC),   1,32'h14};
      vt[9]  = '{1,1,1,32'h100,  1,32'h10, rom(32'h10),  0,32'h18};
      vt[10] = '{1,0,1,0,        0,32'h10, rom(32'h10),  1,32'h100};
      vt[11] = '{1,0,1,0,        1,32'h100,rom(32'h100), 1,32'h104};

      #1;
      chk("rst_valid", 32'(if_valid), 0);
      chk("rst_pc", if_pc, 0);
      chk("rst_instr", if_instr, 0);
      chk("rst_exc", 32'(if_exc), 0);
      chk("rst_en", 32'(imem_en), 0);
      chk("rst_addr", imem_addr, 0);
      @(negedge clk) rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         fe = vt[i].fe; rd = vt[i].rd; rdy = vt[i].rdy; rpc = vt[i].rpc;
         #1;
         chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(vt[i].v));
         chk($sformatf("tbl%0d_pc", i), if_pc, vt[i].pc);
         chk($sformatf("tbl%0d_instr", i), if_instr, vt[i].instr);
         chk($sformatf("tbl%0d_en", i), 32'(imem_en), 32'(vt[i].en));
         chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].addr);
      end

      // PC wrap at the top of the address space
      @(negedge clk); rd = 1; rpc = 32'hFFFF_FFFC; fe = 1; rdy = 1;
      @(negedge clk); rd = 0; #1;
      chk("wrap_en0", 32'(imem_en), 1);
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk); #1;
      chk("wrap_addr1", imem_addr, 32'h0);
      chk("wrap_en1", 32'(imem_en), 1);
      chk("wrap_pc1", if_pc, 32'hFFFF_FFFC);
      @(negedge clk); #1;
      chk("wrap_pc2", if_pc, 32'h0);
      chk("wrap_addr2", imem_addr, 32'h4);

      // asynchronous reset with a full buffer
      @(negedge clk); rdy = 0; #1;
      @(negedge clk); #1;
      chk("ar_full_valid", 32'(if_valid), 1);
      chk("ar_full_en", 32'(imem_en), 0);
      #1 rst = 0; #1;
      chk("ar_valid", 32'(if_valid), 0);
      chk("ar_pc", if_pc, 0);
      chk("ar_en", 32'(imem_en), 0);
      chk("ar_addr", imem_addr, 0);
      @(negedge clk); rst = 1; rdy = 1; #1;
      chk("ar_rel_en", 32'(imem_en), 1);
      chk("ar_rel_addr", imem_addr, 0);
      @(negedge clk); #1;
      chk("ar_rel_valid", 32'(if_valid), 1);
      chk("ar_rel_pc", if_pc, 0);
      chk("ar_rel_instr", if_instr, 32'h0050_0093);

`ifdef FETCH_MISALIGN_TRAP_EN
      @(negedge clk); rd = 1; rpc = 32'h102;
      @(negedge clk); rd = 0; #1;
      chk("trap_valid", 32'(if_valid), 1);
      chk("trap_pc", if_pc, 32'h102);
      chk("trap_exc", 32'(if_exc), 1);
      chk("trap_instr", if_instr, 32'h13);
      chk("trap_en0", 32'(imem_en), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("halt_en", 32'(imem_en), 0);
      end
      @(negedge clk); rd = 1; rpc = 32'h200;
      @(negedge clk); rd = 0; #1;
      chk("resume_en", 32'(imem_en), 1);
      chk("resume_addr", imem_addr, 32'h200);
`endif

      // random traffic against a queue-level reference model
      @(negedge clk); rst = 0; fe = 0; rd = 0; rdy = 0;
      @(negedge clk); rst = 1;
      m_q.delete(); m_pc = 0; m_halt = 0; m_last = '{0, 0, 0};
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         fe  = $urandom_range(0, 9) != 0;
         rdy = $urandom_range(0, 9) < 7;
         rd  = $urandom_range(0, 15) == 0;
         case ($urandom_range(0, 2))
            0:       rpc = $urandom_range(0, 1023);
            1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: rpc = $urandom;
         endcase
         #1;
         m_v   = m_q.size() != 0;
         hd    = m_v ? m_q[0] : m_last;
         m_pop = m_v && rdy;
         m_en  = fe && !rd && !m_halt && (m_q.size() < 2 || m_pop);
         chk("rnd_valid", 32'(if_valid), 32'(m_v));
         chk("rnd_en", 32'(imem_en), 32'(m_en));
         chk("rnd_addr", imem_addr, m_pc);
         chk("rnd_pc", if_pc, hd.pc);
         chk("rnd_instr", if_instr, hd.instr);
         chk("rnd_exc", 32'(if_exc), 32'(hd.exc));
         if (m_v) m_last = m_q[0];
         if (rd) begin
            m_q.delete();
            m_halt = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 0) begin
               m_q.push_back('{rpc, 32'h13, 1'b1});
               m_halt = 1;
            end
`endif
            m_pc = rpc & ~32'h3;
         end else begin
            if (m_pop) void'(m_q.pop_front());
            if (m_en) begin
               m_q.push_back('{m_pc, rom(m_pc), 1'b0});
               m_pc = m_pc + 32'h4;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
